// File: rtl/avg_pkg.sv
// Shared types and constants for the AVG vector processor sequencer.
package avg_pkg;

  localparam int unsigned AVG_ADDR_W = 16;
  localparam int unsigned AVG_WORD_W = 16;
  localparam int unsigned AVG_INST_W = 2 * AVG_WORD_W;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UNF  = 2'b10;

  typedef enum logic [2:0] {
    ST_HALTED,
    ST_FETCH_HI,
    ST_FETCH_LO,
    ST_CAPT,
    ST_EXEC,
    ST_CMD
  } seq_state_t;

  // Byte distance to the next instruction; a zero length still advances one word.
  function automatic logic [AVG_ADDR_W-1:0] pc_step(input logic [2:0] words);
    logic [2:0] eff;
    eff = (words == 3'd0) ? 3'd1 : words;
    return AVG_ADDR_W'({eff, 1'b0});
  endfunction

endpackage

// File: rtl/avg_ret_stack.sv
// JSR/RTS return-address LIFO; overflowing pushes and underflowing pops are dropped.
module avg_ret_stack
  import avg_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [AVG_ADDR_W-1:0] din,
  output logic [AVG_ADDR_W-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SW = IW + 1;

  logic [SW-1:0]         sp_q, sp_d;
  logic [AVG_ADDR_W-1:0] mem_q [DEPTH];
  logic [AVG_ADDR_W-1:0] mem_d [DEPTH];
  logic [IW-1:0]         top_idx;

  assign full    = (sp_q == SW'(DEPTH));
  assign empty   = (sp_q == '0);
  assign top_idx = IW'(sp_q - SW'(1));
  assign dout    = mem_q[top_idx];

  always_comb begin
    sp_d  = sp_q;
    mem_d = mem_q;
    if (clr) begin
      sp_d = '0;
    end else if (push && !full) begin
      mem_d[sp_q[IW-1:0]] = din;
      sp_d                = sp_q + SW'(1);
    end else if (pop && !empty) begin
      sp_d = sp_q - SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sp_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      sp_q  <= sp_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/avg_sequencer.sv
// AVG instruction sequencer: two-word fetch, decoder-driven flow control,
// return stack and valid/ready command hand-off to the vector engine.
module avg_sequencer
  import avg_pkg::*;
#(
  parameter logic [AVG_ADDR_W-1:0] START_ADDR  = 16'h0000,
  parameter int unsigned           STACK_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  go,
  output logic                  halted,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic                  mem_rd,
  output logic [AVG_ADDR_W-1:0] mem_addr,
  input  logic [AVG_WORD_W-1:0] mem_rdata,
  output logic [AVG_INST_W-1:0] inst,
  input  logic                  dcd_vector,
  input  logic                  dcd_center,
  input  logic                  dcd_zWrEn,
  input  logic                  dcd_scalWrEn,
  input  logic                  dcd_jmp,
  input  logic                  dcd_jsr,
  input  logic                  dcd_ret,
  input  logic                  dcd_halt,
  input  logic [AVG_ADDR_W-1:0] dcd_jumpAddr,
  input  logic [2:0]            dcd_pcOffset,
  output logic                  cmd_valid,
  input  logic                  cmd_ready
);

  seq_state_t            state_q, state_d;
  logic [AVG_ADDR_W-1:0] pc_q, pc_d;
  logic [AVG_INST_W-1:0] inst_q, inst_d;
  logic                  halted_q, halted_d;
  logic                  err_q, err_d;
  logic [1:0]            err_code_q, err_code_d;
  logic                  mem_rd_q, mem_rd_d;
  logic [AVG_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic                  cmd_valid_q, cmd_valid_d;

  logic                  stk_push, stk_pop, stk_clr, stk_full, stk_empty;
  logic [AVG_ADDR_W-1:0] stk_dout;
  logic [AVG_ADDR_W-1:0] pc_next;
  logic                  is_cmd;

  assign pc_next = pc_q + pc_step(dcd_pcOffset);
  assign is_cmd  = dcd_vector | dcd_center | dcd_zWrEn | dcd_scalWrEn;

  avg_ret_stack #(.DEPTH(STACK_DEPTH)) u_ret_stack (
    .clk   (clk),
    .rst_b (rst_b),
    .clr   (stk_clr),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (pc_next),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    stk_clr    = 1'b0;

    case (state_q)
      ST_HALTED: begin
        if (go) begin
          pc_d       = START_ADDR;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          stk_clr    = 1'b1;
          state_d    = ST_FETCH_HI;
        end
      end
      ST_FETCH_HI: state_d = ST_FETCH_LO;
      ST_FETCH_LO: begin
        inst_d[AVG_INST_W-1:AVG_WORD_W] = mem_rdata;
        state_d                         = ST_CAPT;
      end
      ST_CAPT: begin
        inst_d[AVG_WORD_W-1:0] = mem_rdata;
        state_d                = ST_EXEC;
      end
      // Flow flags take precedence over command flags.
      ST_EXEC: begin
        if (dcd_halt) begin
          state_d = ST_HALTED;
        end else if (dcd_ret) begin
          if (stk_empty) begin
            err_d      = 1'b1;
            err_code_d = ERR_UNF;
            state_d    = ST_HALTED;
          end else begin
            stk_pop = 1'b1;
            pc_d    = stk_dout;
            state_d = ST_FETCH_HI;
          end
        end else if (dcd_jsr) begin
          if (stk_full) begin
            err_d      = 1'b1;
            err_code_d = ERR_OVF;
            state_d    = ST_HALTED;
          end else begin
            stk_push = 1'b1;
            pc_d     = dcd_jumpAddr;
            state_d  = ST_FETCH_HI;
          end
        end else if (dcd_jmp) begin
          pc_d    = dcd_jumpAddr;
          state_d = ST_FETCH_HI;
        end else if (is_cmd) begin
          state_d = ST_CMD;
        end else begin
          pc_d    = pc_next;
          state_d = ST_FETCH_HI;
        end
      end
      ST_CMD: begin
        if (cmd_ready) begin
          pc_d    = pc_next;
          state_d = ST_FETCH_HI;
        end
      end
      default: state_d = ST_HALTED;
    endcase

    // Outputs are registered against the state being entered.
    halted_d    = (state_d == ST_HALTED);
    cmd_valid_d = (state_d == ST_CMD);
    mem_rd_d    = (state_d == ST_FETCH_HI) || (state_d == ST_FETCH_LO);
    if (state_d == ST_FETCH_HI) begin
      mem_addr_d = pc_d;
    end else if (state_d == ST_FETCH_LO) begin
      mem_addr_d = pc_q + AVG_ADDR_W'(2);
    end else begin
      mem_addr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= ST_HALTED;
      pc_q        <= START_ADDR;
      inst_q      <= '0;
      halted_q    <= 1'b1;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      cmd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      halted_q    <= halted_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      cmd_valid_q <= cmd_valid_d;
    end
  end

  assign halted    = halted_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign inst      = inst_q;
  assign cmd_valid = cmd_valid_q;

endmodule

// File: doc/avg_sequencer.md
Name: avg_sequencer

Overview:
Instruction sequencer for the AVG vector processor.
- Fetches 16-bit words from vector memory and assembles each 32-bit instruction word.
- Presents the word to the external combinational instruction decoder and acts on the decoded control fields.
- Owns the PC and the JSR/RTS return stack.
- Hands drawing/state commands to the downstream vector engine over a valid/ready handshake.

Parameters:
START_ADDR, 16'h0000, byte address loaded into the PC on go.
STACK_DEPTH, 4, number of return-stack entries (power of 2, 2..16).

Ports:
clk  in  1  system clock
rst_b  in  1  asynchronous active-low reset
go  in  1  single-cycle start pulse (CPU VGGO write)
halted  out  1  1 when idle or halted
err  out  1  sticky stack error; cleared by go
err_code  out  2  01 = stack overflow, 10 = underflow, 00 = none
mem_rd  out  1  vector memory read strobe
mem_addr  out  16  byte address, always even
mem_rdata  in  16  read data, valid the cycle after mem_rd
inst  out  32  assembled instruction word to decoder
dcd_vector, dcd_center, dcd_zWrEn, dcd_scalWrEn  in  1 each  decoder command flags
dcd_jmp, dcd_jsr, dcd_ret, dcd_halt  in  1 each  decoder flow flags
dcd_jumpAddr  in  16  jump target, byte address
dcd_pcOffset  in  3  instruction length in 16-bit words
cmd_valid  out  1  inst holds a command for the vector engine
cmd_ready  in  1  vector engine accepts command

Behaviour:
- Reset values:
  - state = HALTED, pc = START_ADDR, inst = 0.
  - Stack pointer sp = 0 and all stack entries = 0.
  - halted = 1, err = 0, err_code = 0.
  - mem_rd = 0, mem_addr = 0, cmd_valid = 0.
- FSM states: HALTED, FETCH_HI, FETCH_LO, CAPT, EXEC, CMD.
- HALTED:
  - On go: pc <= START_ADDR, err/err_code cleared, sp <= 0, next state FETCH_HI.
  - Otherwise remain in HALTED.
- FETCH_HI: mem_rd = 1, mem_addr = pc. Next state FETCH_LO.
- FETCH_LO: mem_rd = 1, mem_addr = pc + 2 (16-bit wrap); inst[31:16] <= mem_rdata. Next state CAPT.
- CAPT: inst[15:0] <= mem_rdata. Next state EXEC.
- EXEC (inst stable; decoder flags valid). Priority: halt > ret > jsr > jmp > command > plain.
  - halt: go to HALTED; pc is not advanced.
  - ret with sp == 0: err = 1, err_code = 10, go to HALTED.
  - ret with sp > 0: sp--, pc <= stack[sp-1], go to FETCH_HI.
  - jsr with sp == STACK_DEPTH: err = 1, err_code = 01, go to HALTED.
  - jsr otherwise: stack[sp] <= pc + 2*dcd_pcOffset, sp++, pc <= dcd_jumpAddr.
  - jmp: pc <= dcd_jumpAddr.
  - After a successful jsr or jmp, go to FETCH_HI.
  - vector | center | zWrEn | scalWrEn: go to CMD.
  - Otherwise: pc <= pc + 2*dcd_pcOffset, go to FETCH_HI.
- CMD:
  - cmd_valid = 1; inst held constant.
  - On cmd_ready: pc <= pc + 2*dcd_pcOffset, go to FETCH_HI.
  - cmd_ready in the same cycle cmd_valid rises completes the transfer in that cycle.
  - cmd_ready while not in CMD is ignored.
- PC arithmetic: 16 bits, modulo 2^16, no overflow flag.
- dcd_pcOffset == 0 in EXEC is treated as 1 so the sequencer always advances.
- Timing:
  - Minimum 4 cycles per non-command instruction.
  - Command instructions take 4 + (cycles until cmd_ready) cycles.
- halted = (state == HALTED), registered. It deasserts the cycle after go.
- go outside HALTED is ignored; no restart.
- rst_b assertion mid-fetch or mid-CMD forces reset values immediately.
  - cmd_valid drops asynchronously.
  - A pending command is lost.

Decomposition:
- Shared package avg_pkg holds:
  - seq_state_t enum.
  - Error code constants ERR_NONE, ERR_OVF, ERR_UNF.
  - AVG_ADDR_W = 16 and AVG_WORD_W = 16.
- One sub-module, avg_ret_stack: STACK_DEPTH x 16 LIFO.
  - Signals: push, pop, din, dout, full, empty.
  - Asynchronous active-low reset.
  - Push when full and pop when empty are ignored internally; the sequencer flags the error.

Test Plan:
- Halt at START_ADDR: go with memory word 0 decoding to halt -> FETCH_HI..EXEC in 4 cycles, halted reasserts, pc stays 0x0000, cmd_valid never set.
- Vector with back-pressure: mem[0..1] = 16'h1234, 16'h5678 decoding to vector (pcOffset = 2); hold cmd_ready = 0 for 5 cycles -> inst = 32'h12345678 held, cmd_valid = 1 for 5 cycles; on ready pc = 0x0004 and next fetch addr = 0x0004.
- JSR/RTS: jsr at pc 0x0000 (pcOffset = 1, jumpAddr = 0x0100) -> next fetch 0x0100, sp = 1; ret at 0x0100 -> next fetch 0x0002, sp = 0.
- Overflow: 5 nested jsr with STACK_DEPTH = 4 -> 5th gives err = 1, err_code = 01, halted = 1; next go clears err.
- Underflow: ret with empty stack -> err_code = 10, halted = 1.
- Wrap and reset: jmp to 0xFFFE with pcOffset = 2 non-jump -> low-word fetch at 0x0000, pc advances to 0x0002. Separately, assert rst_b low during CMD -> cmd_valid = 0 immediately, halted = 1, pc = START_ADDR.
